mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Parametrised load/store unit between the multi-cycle core and the memory bus.
- Replaces the free-running mem_clk / mem_size strobe scheme with a valid/ready handshake on both sides.
- Adds byte-lane steering, sign/zero extension, wait-state tolerance and error reporting.
- Handles 32- or 64-bit data paths; misaligned accesses are split into two bus beats when the option is compiled in.

Parameters:
- DATA_W, 32, bus/register data width; legal values 32 or 64.
- ADDR_W, 32, byte address width.
- NB, DATA_W/8, byte lanes (derived, not overridable).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 byte, 1 half, 2 word, 3 dword.
- req_unsigned  in  1  zero-extend the load when 1; sign-extend when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- rsp_err  out  1  qualifies rsp_valid; access rejected.
- bus_valid  out  1  bus beat request.
- bus_ready  in  1  beat completes when bus_valid && bus_ready.
- bus_we  out  1  beat is a write.
- bus_addr  out  ADDR_W  NB-aligned beat address; low log2(NB) bits are 0.
- bus_be  out  NB  byte enables.
- bus_wdata  out  DATA_W  lane-steered store data.
- bus_rdata  in  DATA_W  read data, valid in the completing cycle.

Behaviour:
Reset:
- Asynchronous, active-low; state goes to IDLE.
- All outputs are 0 except req_ready = 1.

FSM states: IDLE, BEAT0, BEAT1, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch the request and classify it.
  - Illegal size (bytes > NB): go to RESP with err, no bus beat.
  - Misaligned (addr mod bytes != 0) with the split option off: go to RESP with err, no bus beat.
  - Otherwise go to BEAT0.
- BEAT0:
  - bus_valid = 1; bus_addr, bus_be, bus_we and bus_wdata are held stable until bus_ready.
  - On completion, capture the read lanes.
  - Go to BEAT1 if the access crosses an NB boundary; otherwise go to RESP.
- BEAT1:
  - Address = beat0 address + NB, wrapping modulo 2^ADDR_W.
  - Carries the remaining low lanes.
  - On completion, go to RESP.
- RESP:
  - rsp_valid = 1 for exactly one cycle; req_ready = 0.
  - Return to IDLE.

Latency:
- Request accepted in cycle t; bus_valid asserted from t+1.
- Zero wait states: rsp_valid at t+2, or t+3 for a split access.
- Each bus wait cycle adds one cycle.
- Error responses: rsp_valid at t+1.

Throughput: at most one outstanding request; req_ready is 0 in BEAT0, BEAT1 and RESP.

Lane rules:
- off = addr mod NB.
- bus_be = ((1<<bytes)-1) << off, truncated to NB lanes.
- bus_wdata = req_wdata << (8*off).
- Load: extract `bytes` bytes starting at lane off (split accesses wrap into the beat1 lanes), then extend to DATA_W per req_unsigned.
- req_size 2 on DATA_W=64: a signed load sign-extends from bit 31.

Boundaries:
- bus_ready asserted while bus_valid = 0: ignored.
- req_valid asserted outside IDLE: ignored, since req_ready = 0.
- Reset mid-beat: bus_valid drops immediately; no response is produced.
- Store data outside the enabled lanes is don't-care but is driven as 0.

Optional Feature:
- Macro: MAU_MISALIGN_SPLIT_EN.
- Defined: misaligned legal-size accesses are performed as two beats (BEAT0 then BEAT1) and complete without error.
- Undefined: BEAT1 is not built; every misaligned access returns rsp_err = 1 with no bus activity.

Test Plan:
- Load byte, DATA_W=32, addr 0x103, req_unsigned 0, bus_rdata 0x80FFFFFF, zero wait:
  - bus_addr 0x100, bus_be 4'b1000, rsp_valid at t+2.
  - rsp_rdata 0xFFFFFF80, rsp_err 0.
- Store half 0xBEEF to addr 0x202, bus_ready held low 3 cycles:
  - bus_be 4'b1100, bus_wdata 0xBEEF0000, stable for 4 cycles.
  - rsp_valid at t+5, rsp_rdata 0.
- Load word at addr 0x002, split option on:
  - Beat0: addr 0x000, be 4'b1100, rdata 0x3344xxxx.
  - Beat1: addr 0x004, be 4'b0011, rdata 0xxxxx1122.
  - rsp_rdata 0x11223344 at t+3.
- Same load with split option off: rsp_valid and rsp_err at t+1, bus_valid never asserted.
- DATA_W=32, req_size 3: rsp_err 1 at t+1; DATA_W=64, dword load at 0x08: be 8'hFF, single beat.
- Reset asserted while in BEAT0:
  - bus_valid, rsp_valid 0 same cycle; req_ready 1.
  - A new request after release completes normally.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Handshake bundle between the core, the mem_access_unit and the memory bus.
//   req_*  : core request channel (valid/ready)
//   rsp_*  : one-cycle completion pulse back to the core
//   bus_*  : beat channel to memory (valid/ready, NB-aligned beats)
// Modports:
//   slave  : the load/store unit's view
//   master : the environment's view (core + memory model)
interface mem_access_unit_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned NB = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic              bus_valid;
  logic              bus_ready;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [NB-1:0]     bus_be;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ready, bus_rdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit between the multi-cycle core and the memory bus.
// One request at a time: classify, run one bus beat (two when a misaligned access crosses an
// NB-byte boundary), then pulse a response carrying extended load data or an error.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   mau   : mem_access_unit_if.slave (req_*, rsp_*, bus_* signal groups)
// Parameters: DATA_W (32 or 64), ADDR_W (>= 3). NB = DATA_W/8 is derived.
// Build option: define MAU_MISALIGN_SPLIT_EN to perform misaligned legal-size accesses as two
// beats; without it every misaligned access is rejected with rsp_err and no bus activity.
module mem_access_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input logic              clk,
  input logic              reset,
  mem_access_unit_if.slave mau
);
  localparam int unsigned NB   = DATA_W / 8;
  localparam int unsigned OffW = $clog2(NB);

`ifdef MAU_MISALIGN_SPLIT_EN
  localparam bit SplitEn = 1'b1;
`else
  localparam bit SplitEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StBeat0, StBeat1, StResp} state_e;
  state_e state_q, state_d;

  logic              we_q, uns_q, err_q, cross_q;
  logic [1:0]        size_q;
  logic [OffW-1:0]   off_q;
  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] wdata_q, rdata_q, rd0_q;

  // Request classification
  logic [3:0]      req_bytes;
  logic [2:0]      req_mask;
  logic [OffW-1:0] req_off;
  logic            req_illegal, req_misaligned, req_cross, req_err, req_accept;

  assign req_bytes      = 4'd1 << mau.req_size;
  assign req_mask       = 3'(req_bytes - 4'd1);
  assign req_off        = mau.req_addr[OffW-1:0];
  assign req_illegal    = 32'(req_bytes) > NB;
  assign req_misaligned = (mau.req_addr[2:0] & req_mask) != 3'd0;
  assign req_cross      = (32'(req_off) + 32'(req_bytes)) > NB;
  assign req_err        = req_illegal | (req_misaligned & ~SplitEn);
  assign req_accept     = (state_q == StIdle) & mau.req_valid;

  logic bus_active, beat1, fire, last_beat;
  assign bus_active = (state_q == StBeat0) | (state_q == StBeat1);
  assign beat1      = (state_q == StBeat1);
  // bus_ready while no beat is pending has no effect
  assign fire       = bus_active & mau.bus_ready;
  assign last_beat  = beat1 | ~cross_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (mau.req_valid) state_d = req_err ? StResp : StBeat0;
      StBeat0: if (fire) state_d = cross_q ? StBeat1 : StResp;
      StBeat1: if (fire) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Lane steering: both halves of the double-width vectors are used when a split access
  // spills into the following beat.
  logic [3:0]          bytes_q;
  logic [2*NB-1:0]     be_wide;
  logic [DATA_W-1:0]   keep_mask;
  logic [2*DATA_W-1:0] wd_wide, rd_wide;
  logic [DATA_W-1:0]   rd_raw, load_ext;
  logic                sign_bit;

  always_comb begin
    bytes_q   = 4'd1 << size_q;
    be_wide   = (2*NB)'((16'd1 << bytes_q) - 16'd1) << off_q;
    // Zero for shift amounts >= DATA_W, so a full-width access keeps every bit
    keep_mask = ~({DATA_W{1'b1}} << {bytes_q, 3'b000});
    wd_wide   = {{DATA_W{1'b0}}, wdata_q & keep_mask} << {off_q, 3'b000};
    rd_wide   = beat1 ? {mau.bus_rdata, rd0_q} : {{DATA_W{1'b0}}, mau.bus_rdata};
    rd_raw    = DATA_W'(rd_wide >> {off_q, 3'b000});
    unique case (size_q)
      2'd0:    sign_bit = rd_raw[7];
      2'd1:    sign_bit = rd_raw[15];
      2'd2:    sign_bit = rd_raw[31];
      default: sign_bit = rd_raw[DATA_W-1];
    endcase
    load_ext = (rd_raw & keep_mask) | ({DATA_W{~uns_q & sign_bit}} & ~keep_mask);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      cross_q <= 1'b0;
      size_q  <= 2'd0;
      off_q   <= '0;
      base_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd0_q   <= '0;
    end else begin
      if (req_accept) begin
        we_q    <= mau.req_we;
        uns_q   <= mau.req_unsigned;
        err_q   <= req_err;
        cross_q <= req_cross & SplitEn;
        size_q  <= mau.req_size;
        off_q   <= req_off;
        base_q  <= {mau.req_addr[ADDR_W-1:OffW], {OffW{1'b0}}};
        wdata_q <= mau.req_wdata;
        rdata_q <= '0;
      end
      if (fire && !beat1 && cross_q) rd0_q <= mau.bus_rdata;
      if (fire && last_beat) rdata_q <= we_q ? '0 : load_ext;
    end
  end

  assign mau.req_ready = (state_q == StIdle);
  assign mau.rsp_valid = (state_q == StResp);
  assign mau.rsp_err   = mau.rsp_valid & err_q;
  assign mau.rsp_rdata = mau.rsp_valid ? rdata_q : '0;

  // Beat outputs are forced to 0 outside a beat so reset and idle present a quiet bus
  assign mau.bus_valid = bus_active;
  assign mau.bus_we    = bus_active & we_q;
  assign mau.bus_addr  = !bus_active ? '0 : (beat1 ? base_q + ADDR_W'(NB) : base_q);
  assign mau.bus_be    = !bus_active ? '0 : (beat1 ? be_wide[2*NB-1:NB] : be_wide[NB-1:0]);
  assign mau.bus_wdata = !(bus_active && we_q) ? '0 :
                         (beat1 ? wd_wide[2*DATA_W-1:DATA_W] : wd_wide[DATA_W-1:0]);
endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
`ifdef MAU_MISALIGN_SPLIT_EN
  localparam bit Split = 1'b1;
`else
  localparam bit Split = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if #(.DATA_W(32), .ADDR_W(32)) mif32 ();
  mem_access_unit_if #(.DATA_W(64), .ADDR_W(32)) mif64 ();

  mem_access_unit #(.DATA_W(32), .ADDR_W(32)) dut32 (.clk(clk), .reset(reset), .mau(mif32));
  mem_access_unit #(.DATA_W(64), .ADDR_W(32)) dut64 (.clk(clk), .reset(reset), .mau(mif64));

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  // sampled DUT outputs
  logic        s_rdy, s_bv, s_bwe, s_rv, s_err;
  logic [31:0] s_ba;
  logic [7:0]  s_be;
  logic [63:0] s_bwd, s_rd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sample(input bit w64);
    if (w64) begin
      s_rdy = mif64.req_ready; s_bv = mif64.bus_valid; s_bwe = mif64.bus_we;
      s_ba = mif64.bus_addr; s_be = mif64.bus_be; s_bwd = mif64.bus_wdata;
      s_rv = mif64.rsp_valid; s_rd = mif64.rsp_rdata; s_err = mif64.rsp_err;
    end else begin
      s_rdy = mif32.req_ready; s_bv = mif32.bus_valid; s_bwe = mif32.bus_we;
      s_ba = mif32.bus_addr; s_be = 8'(mif32.bus_be); s_bwd = 64'(mif32.bus_wdata);
      s_rv = mif32.rsp_valid; s_rd = 64'(mif32.rsp_rdata); s_err = mif32.rsp_err;
    end
  endtask

  task automatic drive_req(input bit w64, input logic v, input logic we, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr, input logic [63:0] wd);
    if (w64) begin
      mif64.req_valid = v; mif64.req_we = we; mif64.req_size = size;
      mif64.req_unsigned = uns; mif64.req_addr = addr; mif64.req_wdata = wd;
    end else begin
      mif32.req_valid = v; mif32.req_we = we; mif32.req_size = size;
      mif32.req_unsigned = uns; mif32.req_addr = addr; mif32.req_wdata = wd[31:0];
    end
  endtask

  task automatic drive_bus(input bit w64, input logic rdy, input logic [63:0] rd);
    if (w64) begin mif64.bus_ready = rdy; mif64.bus_rdata = rd; end
    else begin mif32.bus_ready = rdy; mif32.bus_rdata = rd[31:0]; end
  endtask

  // One transaction, started just after a negedge with the DUT idle; returns idle.
  // Beat k expects address ak/enables bek/store data wdk, and answers with rdk after `waits`
  // stalled cycles. `poke` drives a bogus request during stalls, which must be ignored.
  task automatic xact(input string tag, input bit w64, input logic we, input logic [1:0] size,
                      input logic uns, input logic [31:0] addr, input logic [63:0] wdata,
                      input int waits, input bit poke,
                      input logic [31:0] a0, input logic [7:0] be0, input logic [63:0] wd0,
                      input logic [63:0] rd0,
                      input logic [31:0] a1, input logic [7:0] be1, input logic [63:0] wd1,
                      input logic [63:0] rd1,
                      input int beats, input int lat, input logic [63:0] exp_rd,
                      input logic exp_err);
    exp_t e;
    int b, w;
    bit done;
    e.rdata = exp_rd; e.err = exp_err; e.lat = lat;
    sb.push_back(e);
    sample(w64);
    check({tag, ":req_ready_idle"}, 64'(s_rdy), 64'd1);
    drive_req(w64, 1'b1, we, size, uns, addr, wdata);
    @(negedge clk);
    drive_req(w64, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 64'd0);
    b = 0; w = 0; done = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      sample(w64);
      if (s_bv) begin
        check({tag, ":bus_addr"}, 64'(s_ba), 64'(b == 0 ? a0 : a1));
        check({tag, ":bus_be"}, 64'(s_be), 64'(b == 0 ? be0 : be1));
        check({tag, ":bus_we"}, 64'(s_bwe), 64'(we));
        if (we) check({tag, ":bus_wdata"}, s_bwd, b == 0 ? wd0 : wd1);
        if (w < waits) begin
          drive_bus(w64, 1'b0, {$urandom, $urandom});
          if (poke) drive_req(w64, 1'b1, 1'b1, 2'd2, 1'b0, 32'h0000_0F00, 64'hFFFF_FFFF);
          w++;
        end else begin
          drive_bus(w64, 1'b1, b == 0 ? rd0 : rd1);
          drive_req(w64, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 64'd0);
          b++;
          w = 0;
        end
      end else begin
        // ready with no beat pending must be ignored
        drive_bus(w64, 1'b1, {$urandom, $urandom});
      end
      if (s_rv) begin
        if (sb.size() == 0) begin
          check({tag, ":sb_empty"}, 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check({tag, ":rsp_rdata"}, s_rd, e.rdata);
          check({tag, ":rsp_err"}, 64'(s_err), 64'(e.err));
          check({tag, ":rsp_latency"}, 64'(c), 64'(e.lat));
        end
        check({tag, ":req_ready_resp"}, 64'(s_rdy), 64'd0);
        done = 1'b1;
      end
      @(negedge clk);
    end
    if (!done) check({tag, ":timeout"}, 64'd0, 64'd1);
    check({tag, ":beat_count"}, 64'(b), 64'(beats));
  endtask

  initial begin
    drive_req(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 64'd0);
    drive_req(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 64'd0);
    drive_bus(1'b0, 1'b0, 64'd0);
    drive_bus(1'b1, 1'b0, 64'd0);
    #12;
    sample(1'b0);
    check("reset:req_ready", 64'(s_rdy), 64'd1);
    check("reset:bus_valid", 64'(s_bv), 64'd0);
    check("reset:rsp_valid", 64'(s_rv), 64'd0);
    check("reset:rsp_rdata", s_rd, 64'd0);
    check("reset:bus_be", 64'(s_be), 64'd0);
    check("reset:rsp_err", 64'(s_err), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // signed byte load from lane 3
    xact("lb_signed", 1'b0, 1'b0, 2'd0, 1'b0, 32'h103, 64'd0, 0, 1'b0,
         32'h100, 8'b1000, 64'd0, 64'h80FF_FFFF, 32'd0, 8'd0, 64'd0, 64'd0,
         1, 2, 64'hFFFF_FF80, 1'b0);
    // half store with 3 wait states; data above the half must not reach the bus
    xact("sh_wait", 1'b0, 1'b1, 2'd1, 1'b0, 32'h202, 64'hDEAD_BEEF, 3, 1'b1,
         32'h200, 8'b1100, 64'hBEEF_0000, 64'd0, 32'd0, 8'd0, 64'd0, 64'd0,
         1, 5, 64'd0, 1'b0);
    // misaligned word load crossing a word boundary
    if (Split)
      xact("lw_split", 1'b0, 1'b0, 2'd2, 1'b0, 32'h002, 64'd0, 0, 1'b0,
           32'h000, 8'b1100, 64'd0, 64'h3344_AAAA, 32'h004, 8'b0011, 64'd0, 64'hBBBB_1122,
           2, 3, 64'h1122_3344, 1'b0);
    else
      xact("lw_misal_err", 1'b0, 1'b0, 2'd2, 1'b0, 32'h002, 64'd0, 0, 1'b0,
           32'd0, 8'd0, 64'd0, 64'd0, 32'd0, 8'd0, 64'd0, 64'd0,
           0, 1, 64'd0, 1'b1);
    // dword on a 32-bit path is always illegal
    xact("ld_illegal32", 1'b0, 1'b0, 2'd3, 1'b0, 32'h008, 64'd0, 0, 1'b0,
         32'd0, 8'd0, 64'd0, 64'd0, 32'd0, 8'd0, 64'd0, 64'd0,
         0, 1, 64'd0, 1'b1);
    xact("lhu", 1'b0, 1'b0, 2'd1, 1'b1, 32'h006, 64'd0, 0, 1'b0,
         32'h004, 8'b1100, 64'd0, 64'h8001_5555, 32'd0, 8'd0, 64'd0, 64'd0,
         1, 2, 64'h0000_8001, 1'b0);
    xact("lh_signed", 1'b0, 1'b0, 2'd1, 1'b0, 32'h000, 64'd0, 1, 1'b0,
         32'h000, 8'b0011, 64'd0, 64'h0000_F00F, 32'd0, 8'd0, 64'd0, 64'd0,
         1, 3, 64'hFFFF_F00F, 1'b0);
    xact("lbu", 1'b0, 1'b0, 2'd0, 1'b1, 32'h001, 64'd0, 0, 1'b0,
         32'h000, 8'b0010, 64'd0, 64'h0000_AB00, 32'd0, 8'd0, 64'd0, 64'd0,
         1, 2, 64'h0000_00AB, 1'b0);
    xact("sw", 1'b0, 1'b1, 2'd2, 1'b0, 32'h010, 64'hCAFE_BABE, 0, 1'b0,
         32'h010, 8'b1111, 64'hCAFE_BABE, 64'd0, 32'd0, 8'd0, 64'd0, 64'd0,
         1, 2, 64'd0, 1'b0);
    if (Split) begin
      xact("sh_split", 1'b0, 1'b1, 2'd1, 1'b0, 32'h003, 64'h0000_BEEF, 0, 1'b0,
           32'h000, 8'b1000, 64'hEF00_0000, 64'd0, 32'h004, 8'b0001, 64'h0000_00BE, 64'd0,
           2, 3, 64'd0, 1'b0);
      xact("lw_wrap", 1'b0, 1'b0, 2'd2, 1'b0, 32'hFFFF_FFFE, 64'd0, 0, 1'b0,
           32'hFFFF_FFFC, 8'b1100, 64'd0, 64'h5566_0000, 32'h0, 8'b0011, 64'd0, 64'h0000_7788,
           2, 3, 64'h7788_5566, 1'b0);
    end else begin
      xact("sh_misal_err", 1'b0, 1'b1, 2'd1, 1'b0, 32'h003, 64'h0000_BEEF, 0, 1'b0,
           32'd0, 8'd0, 64'd0, 64'd0, 32'd0, 8'd0, 64'd0, 64'd0,
           0, 1, 64'd0, 1'b1);
      xact("lw_wrap_err", 1'b0, 1'b0, 2'd2, 1'b0, 32'hFFFF_FFFE, 64'd0, 0, 1'b0,
           32'd0, 8'd0, 64'd0, 64'd0, 32'd0, 8'd0, 64'd0, 64'd0,
           0, 1, 64'd0, 1'b1);
    end

    // 64-bit data path
    xact("ld64", 1'b1, 1'b0, 2'd3, 1'b0, 32'h008, 64'd0, 0, 1'b0,
         32'h008, 8'hFF, 64'd0, 64'h8877_6655_4433_2211, 32'd0, 8'd0, 64'd0, 64'd0,
         1, 2, 64'h8877_6655_4433_2211, 1'b0);
    xact("lw64_signed", 1'b1, 1'b0, 2'd2, 1'b0, 32'h004, 64'd0, 0, 1'b0,
         32'h000, 8'hF0, 64'd0, 64'h8000_0000_1234_5678, 32'd0, 8'd0, 64'd0, 64'd0,
         1, 2, 64'hFFFF_FFFF_8000_0000, 1'b0);
    xact("sd64", 1'b1, 1'b1, 2'd3, 1'b0, 32'h010, 64'h0123_4567_89AB_CDEF, 0, 1'b0,
         32'h010, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'd0, 32'd0, 8'd0, 64'd0, 64'd0,
         1, 2, 64'd0, 1'b0);

    // reset in the middle of a beat: bus drops at once, no response
    drive_req(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h020, 64'd0);
    @(negedge clk);
    drive_req(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 64'd0);
    drive_bus(1'b0, 1'b0, 64'd0);
    sample(1'b0);
    check("rst_mid:in_beat0", 64'(s_bv), 64'd1);
    #2 reset = 1'b0;
    #1 sample(1'b0);
    check("rst_mid:bus_valid", 64'(s_bv), 64'd0);
    check("rst_mid:rsp_valid", 64'(s_rv), 64'd0);
    check("rst_mid:req_ready", 64'(s_rdy), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sample(1'b0);
      check("rst_mid:no_rsp", 64'(s_rv), 64'd0);
    end
    xact("after_rst", 1'b0, 1'b0, 2'd2, 1'b1, 32'h024, 64'd0, 0, 1'b0,
         32'h024, 8'b1111, 64'd0, 64'hA5A5_5A5A, 32'd0, 8'd0, 64'd0, 64'd0,
         1, 2, 64'hA5A5_5A5A, 1'b0);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
